// File: rtl/dmni_mem_sched.sv
// rtl/dmni_mem_sched.sv - round-robin burst scheduler sharing one memory port among three DMNI requesters
module dmni_mem_sched #(
  parameter int MAX_BURST  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [2:0]                 req_i,
  input  logic [2:0]                 we_i,
  input  logic [2:0]                 last_i,
  input  logic [2:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0][31:0]           wdata_i,
  output logic [2:0]                 gnt_o,
  output logic [2:0]                 rvalid_o,
  output logic [31:0]                rdata_o,
  output logic                       mem_en_o,
  output logic [3:0]                 mem_we_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  output logic [31:0]                mem_data_o,
  input  logic [31:0]                mem_data_i,
  output logic                       busy_o
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [2:0]    rvalid_q, rvalid_d;

  logic          own_req, own_we, own_last, beat, others_pending;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    idx1, idx2, winner;
  logic          any_req;

  // Owner 0..2 only, so a 2-bit modulo-3 increment is enough.
  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Round-robin winner search starting at rr_ptr_q.
  always_comb begin
    idx1    = inc3(rr_ptr_q);
    idx2    = inc3(idx1);
    any_req = |req_i;
    winner  = rr_ptr_q;
    if (req_i[rr_ptr_q])  winner = rr_ptr_q;
    else if (req_i[idx1]) winner = idx1;
    else if (req_i[idx2]) winner = idx2;
  end

  // Memory port follows the owner combinationally; everything is zero without an active beat.
  always_comb begin
    own_req        = req_i[owner_q];
    own_we         = we_i[owner_q];
    own_last       = last_i[owner_q];
    beat           = (state_q == BURST) && own_req;
    others_pending = |(req_i & ~gnt_q);
    mem_en_o       = beat;
    mem_we_o       = (beat && own_we) ? 4'hF : 4'h0;
    mem_addr_o     = beat ? addr_i[owner_q] : '0;
    mem_data_o     = beat ? wdata_i[owner_q] : '0;
    cnt_inc        = (beat_cnt_q == MAX_CNT) ? beat_cnt_q : beat_cnt_q + CW'(1);
  end

  // Two-state burst FSM: grant in IDLE, count and release in BURST.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    rvalid_d   = 3'b000;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = BURST;
          owner_d    = winner;
          gnt_d      = 3'(1) << winner;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (!own_req) begin
          state_d  = IDLE;
          gnt_d    = 3'b000;
          rr_ptr_d = inc3(owner_q);
        end else begin
          beat_cnt_d = cnt_inc;
          if (!own_we) rvalid_d = gnt_q;
          // Saturated counter with someone waiting forces a handover on every further beat.
          if (own_last || ((cnt_inc == MAX_CNT) && others_pending)) begin
            state_d  = IDLE;
            gnt_d    = 3'b000;
            rr_ptr_d = inc3(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any burst and drops pending read returns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gnt_q      <= 3'b000;
      owner_q    <= 2'd0;
      rr_ptr_q   <= 2'd0;
      beat_cnt_q <= '0;
      rvalid_q   <= 3'b000;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Read data comes from the memory's own output register, qualified by the registered valid.
  always_comb begin
    gnt_o    = gnt_q;
    rvalid_o = rvalid_q;
    rdata_o  = (|rvalid_q) ? mem_data_i : 32'h0;
    busy_o   = (state_q == BURST);
  end

endmodule

// File: tb/tb_dmni_mem_sched.sv
// tb/tb_dmni_mem_sched.sv - directed bench for dmni_mem_sched
module tb_dmni_mem_sched;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic              clk, rst_n;
  logic [2:0]        req, we, last;
  logic [2:0][31:0]  addr, wdata;
  logic [2:0]        gnt, rvalid;
  logic [31:0]       rdata, mem_addr, mem_dout, mem_din;
  logic              mem_en, busy;
  logic [3:0]        mem_we;

  int tests = 0;
  int fails = 0;

  dmni_mem_sched #(.MAX_BURST(16), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .last_i(last),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_data_o(mem_dout), .mem_data_i(mem_din),
    .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory: data for a read at cycle t is on mem_din during t+1.
  initial mem_din = 32'h0;
  always @(posedge clk) begin
    if (mem_en && mem_we == 4'h0) mem_din <= mem_addr ^ KEY;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 3'b000; we = 3'b000; last = 3'b000;
    addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 3'b111; we = 3'b000; last = 3'b000;
    addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #3;
    tests++; if (gnt !== 3'b000) begin fails++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    tests++; if (rvalid !== 3'b000) begin fails++; $display("FAIL reset_rvalid: got %b want 000", rvalid); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    tests++; if (mem_en !== 1'b0 || mem_we !== 4'h0 || mem_addr !== 32'h0) begin
      fails++; $display("FAIL reset_mem: got en=%b we=%h addr=%h want 0", mem_en, mem_we, mem_addr);
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    req = 3'b000;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    logic [2:0] eg, ev;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) cyc();
      req = (c <= 4) ? 3'b001 : 3'b000;
      we = 3'b000;
      last = (c == 4) ? 3'b001 : 3'b000;
      addr[0] = 32'h100 + 32'(c);
      #3;
      eg = (c >= 1 && c <= 4) ? 3'b001 : 3'b000;
      ev = (c >= 2 && c <= 5) ? 3'b001 : 3'b000;
      tests++; if (gnt !== eg) begin fails++; $display("FAIL sr_gnt c%0d: got %b want %b", c, gnt, eg); end
      tests++; if (busy !== (eg != 3'b000)) begin fails++; $display("FAIL sr_busy c%0d: got %b want %b", c, busy, eg != 3'b000); end
      tests++; if (rvalid !== ev) begin fails++; $display("FAIL sr_rvalid c%0d: got %b want %b", c, rvalid, ev); end
      if (eg != 3'b000) begin
        tests++; if (mem_en !== 1'b1 || mem_we !== 4'h0 || mem_addr !== 32'h100 + 32'(c)) begin
          fails++; $display("FAIL sr_mem c%0d: got en=%b we=%h addr=%h want 1 0 %h", c, mem_en, mem_we, mem_addr, 32'h100 + 32'(c));
        end
      end
      if (ev != 3'b000) begin
        tests++; if (rdata !== ((32'h100 + 32'(c - 1)) ^ KEY)) begin
          fails++; $display("FAIL sr_rdata c%0d: got %h want %h", c, rdata, (32'h100 + 32'(c - 1)) ^ KEY);
        end
      end
    end
    // rr_ptr is now 1: with requesters 0 and 2 pending, 2 must win.
    cyc();
    req = 3'b101; we = 3'b101; last = 3'b101;
    #3;
    tests++; if (gnt !== 3'b000) begin fails++; $display("FAIL sr_idle_c6: got %b want 000", gnt); end
    cyc();
    #3;
    tests++; if (gnt !== 3'b100) begin fails++; $display("FAIL sr_rrptr: got %b want 100", gnt); end
    cyc();
    req = 3'b000;
    #3;
    tests++; if (gnt !== 3'b000) begin fails++; $display("FAIL sr_after_rr: got %b want 000", gnt); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [8];
    logic [31:0] ea;
    exp_g = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    do_reset();
    req = 3'b111; we = 3'b111; last = 3'b111;
    addr[0] = 32'h00; addr[1] = 32'h10; addr[2] = 32'h20;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc();
      #3;
      tests++; if (gnt !== exp_g[c]) begin fails++; $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt, exp_g[c]); end
      if (exp_g[c] != 3'b000) begin
        ea = (exp_g[c] == 3'b001) ? 32'h00 : (exp_g[c] == 3'b010) ? 32'h10 : 32'h20;
        tests++; if (mem_addr !== ea || mem_we !== 4'hF) begin
          fails++; $display("FAIL rr_mem c%0d: got addr=%h we=%h want %h F", c, mem_addr, mem_we, ea);
        end
      end
    end
    cyc();
    req = 3'b000;
  endtask

  task automatic test_preempt();
    int n1;
    logic [2:0] eg;
    do_reset();
    for (int c = 0; c <= 44; c++) begin
      if (c > 0) cyc();
      n1 = (c == 0) ? 0 : (c <= 16) ? c - 1 : (c <= 19) ? 16 : c - 4;
      req = {(c <= 18), (c < 44), 1'b0};
      we = 3'b110;
      last = {1'b1, (n1 == 39), 1'b0};
      addr[1] = 32'h2000 + 32'(n1); wdata[1] = 32'hD000 + 32'(n1);
      addr[2] = 32'h3000;           wdata[2] = 32'hEEEE;
      #3;
      eg = ((c >= 1 && c <= 16) || (c >= 20 && c <= 43)) ? 3'b010 : (c == 18) ? 3'b100 : 3'b000;
      tests++; if (gnt !== eg) begin fails++; $display("FAIL pre_gnt c%0d: got %b want %b", c, gnt, eg); end
      if (eg == 3'b010) begin
        tests++; if (mem_addr !== 32'h2000 + 32'(n1) || mem_dout !== 32'hD000 + 32'(n1) || mem_we !== 4'hF) begin
          fails++; $display("FAIL pre_mem1 c%0d: got addr=%h data=%h we=%h want %h %h F", c, mem_addr, mem_dout, mem_we, 32'h2000 + 32'(n1), 32'hD000 + 32'(n1));
        end
      end
      if (eg == 3'b100) begin
        tests++; if (mem_addr !== 32'h3000 || mem_dout !== 32'hEEEE) begin
          fails++; $display("FAIL pre_mem2 c%0d: got addr=%h data=%h want 3000 EEEE", c, mem_addr, mem_dout);
        end
      end
    end
  endtask

  task automatic test_long_burst();
    logic [2:0] eg, ev;
    do_reset();
    for (int c = 0; c <= 21; c++) begin
      if (c > 0) cyc();
      req = (c <= 20) ? 3'b001 : 3'b000;
      we = 3'b000;
      last = (c == 20) ? 3'b001 : 3'b000;
      addr[0] = 32'h400 + 32'(c);
      #3;
      eg = (c >= 1 && c <= 20) ? 3'b001 : 3'b000;
      ev = (c >= 2 && c <= 21) ? 3'b001 : 3'b000;
      tests++; if (gnt !== eg) begin fails++; $display("FAIL lb_gnt c%0d: got %b want %b", c, gnt, eg); end
      tests++; if (rvalid !== ev) begin fails++; $display("FAIL lb_rvalid c%0d: got %b want %b", c, rvalid, ev); end
      if (ev != 3'b000) begin
        tests++; if (rdata !== ((32'h400 + 32'(c - 1)) ^ KEY)) begin
          fails++; $display("FAIL lb_rdata c%0d: got %h want %h", c, rdata, (32'h400 + 32'(c - 1)) ^ KEY);
        end
      end
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) cyc();
      req = (c <= 2) ? 3'b001 : 3'b000;
      we = 3'b001; last = 3'b000;
      addr[0] = 32'h600 + 32'(c);
      #3;
      if (c == 1 || c == 2) begin
        tests++; if (gnt !== 3'b001 || mem_en !== 1'b1) begin
          fails++; $display("FAIL rd_beat c%0d: got gnt=%b en=%b want 001 1", c, gnt, mem_en);
        end
      end
      if (c == 3) begin
        tests++; if (busy !== 1'b1 || mem_en !== 1'b0 || mem_we !== 4'h0 || mem_addr !== 32'h0) begin
          fails++; $display("FAIL rd_drop: got busy=%b en=%b we=%h addr=%h want 1 0 0 0", busy, mem_en, mem_we, mem_addr);
        end
      end
      if (c == 4) begin
        tests++; if (gnt !== 3'b000 || busy !== 1'b0 || mem_en !== 1'b0) begin
          fails++; $display("FAIL rd_idle: got gnt=%b busy=%b en=%b want 000 0 0", gnt, busy, mem_en);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b001; we = 3'b001; last = 3'b001;
    cyc();
    #3;
    tests++; if (gnt !== 3'b001) begin fails++; $display("FAIL rm_first: got %b want 001", gnt); end
    cyc();
    req = 3'b001; we = 3'b000; last = 3'b000; addr[0] = 32'h500;
    cyc();
    cyc();
    #3;
    tests++; if (rvalid !== 3'b001) begin fails++; $display("FAIL rm_rvalid_pre: got %b want 001", rvalid); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (gnt !== 3'b000 || rvalid !== 3'b000 || rdata !== 32'h0 || busy !== 1'b0) begin
      fails++; $display("FAIL rm_async: got gnt=%b rv=%b rdata=%h busy=%b want 0", gnt, rvalid, rdata, busy);
    end
    tests++; if (mem_en !== 1'b0 || mem_we !== 4'h0 || mem_addr !== 32'h0 || mem_dout !== 32'h0) begin
      fails++; $display("FAIL rm_mem: got en=%b we=%h addr=%h data=%h want 0", mem_en, mem_we, mem_addr, mem_dout);
    end
    cyc();
    rst_n = 1'b1;
    req = 3'b101; we = 3'b101; last = 3'b101;
    #3;
    tests++; if (rvalid !== 3'b000 || gnt !== 3'b000) begin
      fails++; $display("FAIL rm_post: got rv=%b gnt=%b want 000 000", rvalid, gnt);
    end
    cyc();
    #3;
    tests++; if (gnt !== 3'b001) begin fails++; $display("FAIL rm_rrptr: got %b want 001", gnt); end
    tests++; if (rvalid !== 3'b000) begin fails++; $display("FAIL rm_no_rvalid: got %b want 000", rvalid); end
    cyc();
    req = 3'b000;
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_preempt();
    test_long_burst();
    test_req_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
